// File: rtl/fifo_defs.sv
// Shared defaults for the async FIFO pointer logic.
package fifo_defs;

  localparam int unsigned CNT_WIDTH_DEF   = 5;
  localparam int unsigned FIFO_DEPTH      = 2 ** CNT_WIDTH_DEF;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/gray2bin.sv
// Gray to binary conversion: each binary bit is the XOR of all Gray bits from the MSB down to it.
module gray2bin #(
  parameter int unsigned DATA_WIDTH = 6
) (
  input  logic [DATA_WIDTH-1:0] gray_i,
  output logic [DATA_WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_ptr_sync_cmp.sv
// Synchronizes the remote Gray pointer, compares it with the local one for full/empty,
// and (with FIFO_PTR_LEVEL_EN defined) provides a registered fill level and almost flag.
module fifo_ptr_sync_cmp
  import fifo_defs::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned WR_SIDE     = 1,
  parameter int unsigned ALMOST_TH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CNT_WIDTH:0]   local_ptr_gray_i,
  input  logic [CNT_WIDTH:0]   remote_ptr_gray_i,
  output logic                 flag_o,
  output logic                 almost_o,
  output logic [CNT_WIDTH:0]   level_o,
  output logic [CNT_WIDTH:0]   remote_ptr_sync_o
);

  localparam int unsigned PW    = CNT_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** CNT_WIDTH;
  // Full pattern: the two top Gray bits of the local pointer are inverted versus the remote one.
  localparam logic [PW-1:0] FULL_MASK = PW'(2'b11) << (CNT_WIDTH - 1);
  localparam logic ALMOST_RST = (WR_SIDE == 0);

  logic [PW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= remote_ptr_gray_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign remote_ptr_sync_o = sync_q[SYNC_STAGES-1];

  // Left combinational so a local increment blocks the counter in the same cycle.
  always_comb begin
    if (WR_SIDE != 0) flag_o = (local_ptr_gray_i == (sync_q[SYNC_STAGES-1] ^ FULL_MASK));
    else              flag_o = (local_ptr_gray_i == sync_q[SYNC_STAGES-1]);
  end

`ifdef FIFO_PTR_LEVEL_EN
  logic [PW-1:0] local_bin;
  logic [PW-1:0] remote_bin;
  logic [PW-1:0] level_d, level_q;
  logic          almost_d, almost_q;
  logic [31:0]   free_slots;

  gray2bin #(.DATA_WIDTH(PW)) u_g2b_local (
    .gray_i (local_ptr_gray_i),
    .bin_o  (local_bin)
  );

  gray2bin #(.DATA_WIDTH(PW)) u_g2b_remote (
    .gray_i (sync_q[SYNC_STAGES-1]),
    .bin_o  (remote_bin)
  );

  always_comb begin
    if (WR_SIDE != 0) level_d = local_bin - remote_bin;
    else              level_d = remote_bin - local_bin;
    free_slots = DEPTH - 32'(level_d);
    if (WR_SIDE != 0) almost_d = (free_slots <= ALMOST_TH);
    else              almost_d = (32'(level_d) <= ALMOST_TH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q  <= '0;
      almost_q <= ALMOST_RST;
    end else begin
      level_q  <= level_d;
      almost_q <= almost_d;
    end
  end

  assign level_o  = level_q;
  assign almost_o = almost_q;
`else
  assign level_o  = '0;
  assign almost_o = ALMOST_RST;
`endif

endmodule

// File: tb/tb_fifo_ptr_sync_cmp.sv
// Checks a write-side and a read-side instance against an arithmetic pointer model.
module tb_fifo_ptr_sync_cmp;

  localparam int unsigned CW    = 5;
  localparam int unsigned PW    = CW + 1;
  localparam int unsigned SS    = 2;
  localparam int unsigned TH    = 4;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned M     = 63;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] wl_g, wr_g, rl_g, rr_g;
  logic          wflag, walm, rflag, ralm;
  logic [PW-1:0] wlev, wsync, rlev, rsync;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned wl, wrp, rl, rrp;
  int unsigned wq[$];
  int unsigned rq[$];
  int unsigned exp_wlev, exp_rlev;

  always #5 clk = ~clk;

  fifo_ptr_sync_cmp #(.CNT_WIDTH(CW), .SYNC_STAGES(SS), .WR_SIDE(1), .ALMOST_TH(TH)) u_wr (
    .clk_i             (clk),
    .rst_i             (rst),
    .local_ptr_gray_i  (wl_g),
    .remote_ptr_gray_i (wr_g),
    .flag_o            (wflag),
    .almost_o          (walm),
    .level_o           (wlev),
    .remote_ptr_sync_o (wsync)
  );

  fifo_ptr_sync_cmp #(.CNT_WIDTH(CW), .SYNC_STAGES(SS), .WR_SIDE(0), .ALMOST_TH(TH)) u_rd (
    .clk_i             (clk),
    .rst_i             (rst),
    .local_ptr_gray_i  (rl_g),
    .remote_ptr_gray_i (rr_g),
    .flag_o            (rflag),
    .almost_o          (ralm),
    .level_o           (rlev),
    .remote_ptr_sync_o (rsync)
  );

  function automatic logic [PW-1:0] to_gray(int unsigned b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    wl_g = to_gray(wl);
    wr_g = to_gray(wrp);
    rl_g = to_gray(rl);
    rr_g = to_gray(rrp);
  endtask

  task automatic model_reset();
    wq.delete();
    rq.delete();
    for (int i = 0; i < int'(SS); i++) begin
      wq.push_back(0);
      rq.push_back(0);
    end
    exp_wlev = 0;
    exp_rlev = 0;
  endtask

  task automatic check_all();
    int unsigned ws;
    int unsigned rs;
    int unsigned free_slots;
    ws = wq[0];
    rs = rq[0];
    chk("wr_sync",  32'(wsync), 32'(to_gray(ws)));
    chk("wr_full",  32'(wflag), 32'(((wl - ws) & M) == DEPTH));
    chk("rd_sync",  32'(rsync), 32'(to_gray(rs)));
    chk("rd_empty", 32'(rflag), 32'(rl == rs));
`ifdef FIFO_PTR_LEVEL_EN
    free_slots = DEPTH - exp_wlev;
    chk("wr_level",  32'(wlev), exp_wlev);
    chk("wr_almost", 32'(walm), 32'(free_slots <= TH));
    chk("rd_level",  32'(rlev), exp_rlev);
    chk("rd_almost", 32'(ralm), 32'(exp_rlev <= TH));
`else
    free_slots = 0;
    chk("wr_level",  32'(wlev), 32'(free_slots));
    chk("wr_almost", 32'(walm), 32'd0);
    chk("rd_level",  32'(rlev), 32'd0);
    chk("rd_almost", 32'(ralm), 32'd1);
`endif
  endtask

  // Levels seen at an edge use the synchronized pointer from before that edge.
  task automatic tick();
    int unsigned wps;
    int unsigned rps;
    wps = wq[0];
    rps = rq[0];
    @(posedge clk);
    exp_wlev = (wl - wps) & M;
    exp_rlev = (rps - rl) & M;
    wq.push_back(wrp);
    void'(wq.pop_front());
    rq.push_back(rrp);
    void'(rq.pop_front());
    #1;
    check_all();
  endtask

  initial begin
    int unsigned ws;
    int unsigned rs;
    rst = 1'b1;
    wl = 0; wrp = 0; rl = 0; rrp = 0;
    drive();
    model_reset();
    #2;
    check_all();
    #5 rst = 1'b0;

    // Read side: one remote write
    rrp = 1; drive();
    tick(); tick(); tick();

    // Write side: full at local 32, cleared by a remote read
    wl = 32; drive();
    #1 check_all();
    tick();
    wrp = 1; drive();
    tick(); tick(); tick();

    // Wrap-around
    wrp = 40; drive();
    tick(); tick();
    wl = 63; drive(); tick();
    wl = 0;  drive(); tick(); tick();
    wl = 8;  drive();
    #1 check_all();
    tick();

    // Almost threshold: level 27 then 28
    wl = 3; drive(); tick();
    wl = 4; drive(); tick(); tick();

    // Reset mid-operation at level 17
    wl = 57; drive(); tick(); tick();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
    tick(); tick(); tick();

    // Random traffic with legal pointer motion
    for (int n = 0; n < 300; n++) begin
      ws = wq[0];
      rs = rq[0];
      if (((wl - ws) & M) != DEPTH && $urandom_range(1, 0) == 1) wl = (wl + 1) & M;
      if (wl != wrp && $urandom_range(1, 0) == 1) wrp = (wrp + 1) & M;
      if (rl != rs && $urandom_range(1, 0) == 1) rl = (rl + 1) & M;
      if (((rrp - rl) & M) < DEPTH && $urandom_range(1, 0) == 1) rrp = (rrp + 1) & M;
      drive();
      #1 check_all();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_sync_cmp.md
Name: fifo_ptr_sync_cmp

Overview:
Consumer of the Gray pointer produced by a FIFO pointer counter.
Brings the opposite-domain Gray pointer into the local clock through a flop synchronizer. Compares it with the local Gray pointer and produces the full flag (write side) or the empty flag (read side). Also produces a registered fill level and an almost-threshold flag.
flag_o feeds back into the local counter's forbid input. One instance sits in each clock domain of an async FIFO.

Parameters:
CNT_WIDTH, 5, address width; pointers are CNT_WIDTH+1 bits; FIFO depth = 2**CNT_WIDTH
SYNC_STAGES, 2, synchronizer flop count for the remote pointer, legal range 2..4
WR_SIDE, 1, 1 = write-domain instance (flag_o = full), 0 = read-domain instance (flag_o = empty)
ALMOST_TH, 4, almost_o threshold in entries (write side: free slots; read side: stored entries)

Ports:
clk_i  input  1  local domain clock
rst_i  input  1  asynchronous reset, active-high
local_ptr_gray_i  input  CNT_WIDTH+1  local Gray pointer, already registered in clk_i domain
remote_ptr_gray_i  input  CNT_WIDTH+1  opposite-domain Gray pointer, asynchronous to clk_i
flag_o  output  1  full (WR_SIDE=1) or empty (WR_SIDE=0); drives the counter's forbid input
almost_o  output  1  almost-full / almost-empty
level_o  output  CNT_WIDTH+1  entries currently stored, as seen from this domain
remote_ptr_sync_o  output  CNT_WIDTH+1  last synchronizer stage, Gray coded

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-high (rst_i). All flops clear on rst_i asserted, with no dependence on clk_i.
- Reset values:
  - sync chain = 0, remote_ptr_sync_o = 0, level_o = 0
  - flag_o: 0 when WR_SIDE=1; 1 when WR_SIDE=0
  - almost_o: 0 when WR_SIDE=1; 1 when WR_SIDE=0, provided ALMOST_TH >= 0 holds
- Synchronizer:
  - remote_ptr_gray_i passes through SYNC_STAGES flops.
  - No logic is allowed between the flops.
  - Latency from input to remote_ptr_sync_o is SYNC_STAGES cycles.
- flag_o is combinational from the local pointer input and the last sync stage only. No extra register, so a counter increment is seen in the same cycle and overrun/underrun is impossible.
  - Full: local == {~sync[CNT_WIDTH:CNT_WIDTH-1], sync[CNT_WIDTH-2:0]}.
  - Empty: local == sync.
- Level:
  - Both pointers are converted Gray->binary.
  - Write side: level = local_bin - sync_bin. Read side: level = sync_bin - local_bin.
  - Arithmetic is modulo 2**(CNT_WIDTH+1), so wrap-around needs no special case.
  - level_o is registered: 1-cycle latency after the pointer change.
- almost_o is registered, same cycle as level_o.
  - Write side: (2**CNT_WIDTH - level) <= ALMOST_TH.
  - Read side: level <= ALMOST_TH.
- Flags are pessimistic by design:
  - full deasserts SYNC_STAGES+0..1 cycles after the remote read.
  - empty deasserts SYNC_STAGES+0..1 cycles after the remote write.
- Simultaneous local and remote pointer change: the local change is visible immediately, the remote change after the sync latency. No arbitration is needed.
- Reset mid-operation: all state returns to the reset values at once. The FIFO-level reset requirement is that both domains reset together.

Optional Feature:
FIFO_PTR_LEVEL_EN
- Defined: gray2bin conversion, subtractor, level_o and almost_o registers are present as described.
- Undefined: level_o and almost_o are tied to their reset values. Only the synchronizer and flag_o logic remain, and they are unchanged.

Decomposition:
- Shared package/header fifo_defs:
  - CNT_WIDTH default
  - FIFO_DEPTH = 2**CNT_WIDTH
  - SYNC_STAGES default
- Sub-module gray2bin, DATA_WIDTH parameter. Companion of the existing bin2gray; prefix-XOR from the MSB down. Instantiated twice.

Test Plan:
- Reset, WR_SIDE=0, CNT_WIDTH=5: rst_i=1 with no clock -> flag_o=1, almost_o=1, level_o=0, remote_ptr_sync_o=0.
- Read side, remote Gray 0x00->0x01 (one write), local 0x00: remote_ptr_sync_o=0x01 after 2 clocks; flag_o drops that cycle; level_o=1 one cycle later.
- Write side, local bin 32 (Gray 0x30), remote 0: flag_o=1 the same cycle; level_o=32, almost_o=1 next cycle.
  - Remote advances to bin 1 (Gray 0x01) -> flag_o=0 after 2 clocks.
- Wrap-around, write side: local bin 63->0 (Gray 0x20->0x00), remote bin 40 (Gray 0x3C) -> level_o=24, flag_o=0.
  - Then local bin 8 (Gray 0x0C) -> level_o=32, flag_o=1.
- Almost threshold, write side, ALMOST_TH=4: level 27 -> almost_o=0; level 28 -> almost_o=1, one cycle after the change.
- Reset mid-operation at level 17 -> all outputs at reset values immediately. Recovery from the resynchronized pointers after 2 clocks.
- FIFO_PTR_LEVEL_EN undefined: repeat the first four scenarios -> flag_o identical; level_o constantly 0.
